// File: rtl/rv_multicycle_ctrl.sv
// Multicycle control FSM for an RV32I core: fetch/decode/exec/mem/wb sequencing.
// Optional macro RV_CTRL_PERF_EN adds 64-bit cycle and retired-instruction counters.
module rv_multicycle_ctrl #(
  parameter int IMEM_TIMEOUT = 0,
  parameter int DMEM_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  op,
  input  logic [2:0]  func,
  input  logic        br_taken,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic [1:0]  wb_sel,
  output logic        rf_we,
  output logic [2:0]  state,
`ifdef RV_CTRL_PERF_EN
  output logic [63:0] cycle_cnt,
  output logic [63:0] instret_cnt,
`endif
  output logic        halted,
  output logic        illegal
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam int TMAX = (IMEM_TIMEOUT > DMEM_TIMEOUT) ? IMEM_TIMEOUT : DMEM_TIMEOUT;
  localparam int CW   = (TMAX < 1) ? 1 : $clog2(TMAX + 1);

  state_t        state_r;
  state_t        next_s;
  logic [6:0]    op_r;
  logic [2:0]    func_r;
  logic [CW-1:0] wait_r;
  logic          wait_inc_s;
  logic          fault_s;
  logic          halted_r;
  logic          illegal_r;
  logic          unused_func;

  // funct3 is latched alongside op, but no control decision depends on it.
  assign unused_func = ^func_r;

  function automatic logic op_supported(input logic [6:0] o);
    case (o)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
      OP_LOAD, OP_STORE, OP_IMM, OP_REG: op_supported = 1'b1;
      default:                           op_supported = 1'b0;
    endcase
  endfunction

  // Next-state selection, wait-counter advance and fault detection.
  always_comb begin
    next_s     = state_r;
    wait_inc_s = 1'b0;
    fault_s    = 1'b0;
    case (state_r)
      S_FETCH: begin
        if (imem_ready) begin
          next_s = S_DECODE;
        end else if (IMEM_TIMEOUT != 0) begin
          if (int'(wait_r) + 1 >= IMEM_TIMEOUT) begin
            next_s  = S_HALT;
            fault_s = 1'b1;
          end else begin
            wait_inc_s = 1'b1;
          end
        end else begin
          next_s = S_FETCH;
        end
      end
      S_DECODE: begin
        if (op_supported(op)) begin
          next_s = S_EXEC;
        end else begin
          next_s  = S_HALT;
          fault_s = 1'b1;
        end
      end
      S_EXEC: begin
        case (op_r)
          OP_BRANCH:         next_s = S_FETCH;
          OP_LOAD, OP_STORE: next_s = S_MEM;
          default:           next_s = S_WB;
        endcase
      end
      S_MEM: begin
        if (dmem_ready) begin
          next_s = (op_r == OP_STORE) ? S_FETCH : S_WB;
        end else if (DMEM_TIMEOUT != 0) begin
          if (int'(wait_r) + 1 >= DMEM_TIMEOUT) begin
            next_s  = S_HALT;
            fault_s = 1'b1;
          end else begin
            wait_inc_s = 1'b1;
          end
        end else begin
          next_s = S_MEM;
        end
      end
      S_WB:    next_s = S_FETCH;
      S_HALT:  next_s = S_HALT;
      default: begin
        next_s  = S_HALT;
        fault_s = 1'b1;
      end
    endcase
  end

`ifdef RV_CTRL_PERF_EN
  logic [63:0] cycle_r;
  logic [63:0] instret_r;
  assign cycle_cnt   = cycle_r;
  assign instret_cnt = instret_r;
`endif

  // State register, opcode latch, wait counter and sticky status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= S_FETCH;
      op_r      <= 7'd0;
      func_r    <= 3'd0;
      wait_r    <= '0;
      halted_r  <= 1'b0;
      illegal_r <= 1'b0;
`ifdef RV_CTRL_PERF_EN
      cycle_r   <= 64'd0;
      instret_r <= 64'd0;
`endif
    end else begin
      state_r <= next_s;
      if (state_r == S_DECODE) begin
        op_r   <= op;
        func_r <= func;
      end else begin
        op_r   <= op_r;
        func_r <= func_r;
      end
      wait_r    <= wait_inc_s ? wait_r + {{(CW-1){1'b0}}, 1'b1} : '0;
      halted_r  <= halted_r | (next_s == S_HALT);
      illegal_r <= illegal_r | fault_s;
`ifdef RV_CTRL_PERF_EN
      if (state_r != S_HALT) cycle_r <= cycle_r + 64'd1;
      if (next_s == S_FETCH &&
          (state_r == S_EXEC || state_r == S_MEM || state_r == S_WB))
        instret_r <= instret_r + 64'd1;
`endif
    end
  end

  assign state   = state_r;
  assign halted  = halted_r;
  assign illegal = illegal_r;

  // Datapath controls decoded from state and latched opcode; forced idle while in reset.
  always_comb begin
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = 2'd0;
    alu_a_sel = 1'b0;
    alu_b_sel = 1'b0;
    wb_sel    = 2'd0;
    rf_we     = 1'b0;
    if (!rst) begin
      case (state_r)
        S_FETCH: begin
          imem_req = 1'b1;
          ir_we    = imem_ready;
        end
        S_EXEC: begin
          case (op_r)
            OP_IMM, OP_LOAD, OP_STORE: alu_b_sel = 1'b1;
            OP_AUIPC: begin
              alu_a_sel = 1'b1;
              alu_b_sel = 1'b1;
            end
            OP_BRANCH: begin
              pc_we  = 1'b1;
              pc_sel = br_taken ? 2'd1 : 2'd0;
            end
            OP_JAL: begin
              pc_we  = 1'b1;
              pc_sel = 2'd1;
            end
            OP_JALR: begin
              alu_b_sel = 1'b1;
              pc_we     = 1'b1;
              pc_sel    = 2'd2;
            end
            default: alu_b_sel = 1'b0;
          endcase
        end
        S_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = (op_r == OP_STORE);
          pc_we    = dmem_ready && (op_r == OP_STORE);
        end
        S_WB: begin
          rf_we = 1'b1;
          case (op_r)
            OP_LOAD:         wb_sel = 2'd1;
            OP_JAL, OP_JALR: wb_sel = 2'd2;
            OP_LUI:          wb_sel = 2'd3;
            default:         wb_sel = 2'd0;
          endcase
          // Jumps already moved pc in EXEC; WB only writes the link register.
          pc_we = (op_r != OP_JAL) && (op_r != OP_JALR);
        end
        default: imem_req = 1'b0;
      endcase
    end else begin
      imem_req = 1'b0;
    end
  end

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Self-checking bench for rv_multicycle_ctrl: directed scenarios plus randomized
// instruction streams checked cycle by cycle against a per-instruction phase model.
module tb_rv_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] func;
  logic       br_taken, imem_ready, dmem_ready;
  logic       imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we, alu_a_sel, alu_b_sel;
  logic [1:0] pc_sel, wb_sel;
  logic [2:0] state;
  logic       halted, illegal;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       imem_req, dmem_req, dmem_we, ir_we, pc_we;
    logic [1:0] pc_sel;
    logic       a_sel, b_sel;
    logic [1:0] wb_sel;
    logic       rf_we;
    logic [2:0] st;
    logic       halted, illegal;
  } obs_t;

  obs_t obs;
  assign obs = {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, alu_a_sel, alu_b_sel,
                wb_sel, rf_we, state, halted, illegal};

  localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111,
                         JALR = 7'b1100111, BRANCH = 7'b1100011, LOAD = 7'b0000011,
                         STORE = 7'b0100011, OPIMM = 7'b0010011, OPR = 7'b0110011;
  logic [6:0] legal_ops [9] = '{LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OPR};

  rv_multicycle_ctrl #(.IMEM_TIMEOUT(5), .DMEM_TIMEOUT(0)) dut (
    .clk(clk), .rst(rst), .op(op), .func(func), .br_taken(br_taken),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_we(ir_we), .pc_we(pc_we),
    .pc_sel(pc_sel), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .wb_sel(wb_sel),
    .rf_we(rf_we), .state(state), .halted(halted), .illegal(illegal));

  always #5 clk = ~clk;

  function automatic obs_t quiet(input logic [2:0] st);
    obs_t e = '0;
    e.st = st;
    return e;
  endfunction

  task automatic check(input obs_t e, input string tag);
    checks++;
    assert (obs === e) else begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, e);
      $error("%s observed=%h expected=%h", tag, obs, e);
    end
  endtask

  // Drive one cycle's inputs just after the rising edge, check mid-cycle, advance.
  task automatic step(input logic imr, input logic dmr, input logic [6:0] opv,
                      input logic br, input obs_t e, input string tag);
    imem_ready = imr;
    dmem_ready = dmr;
    op         = opv;
    func       = 3'($urandom);
    br_taken   = br;
    #2;
    check(e, tag);
    @(posedge clk);
    #1;
  endtask

  // Walks one instruction through the model's phase list, checking every cycle.
  task automatic run_instr(input logic [6:0] opc, input logic br, input int fw,
                           input int mw, input logic abort_mem, input string tag);
    obs_t e;
    logic is_mem  = (opc == LOAD) || (opc == STORE);
    logic is_jump = (opc == JAL) || (opc == JALR);
    for (int i = 0; i < fw; i++) begin
      e = quiet(3'd0); e.imem_req = 1'b1;
      step(1'b0, 1'($urandom), 7'($urandom), 1'($urandom), e, {tag, ":fetch_wait"});
    end
    e = quiet(3'd0); e.imem_req = 1'b1; e.ir_we = 1'b1;
    step(1'b1, 1'($urandom), 7'($urandom), 1'($urandom), e, {tag, ":fetch"});
    step(1'($urandom), 1'($urandom), opc, 1'($urandom), quiet(3'd1), {tag, ":decode"});
    e = quiet(3'd2);
    case (opc)
      OPIMM, LOAD, STORE: e.b_sel = 1'b1;
      AUIPC:  begin e.a_sel = 1'b1; e.b_sel = 1'b1; end
      BRANCH: begin e.pc_we = 1'b1; e.pc_sel = br ? 2'd1 : 2'd0; end
      JAL:    begin e.pc_we = 1'b1; e.pc_sel = 2'd1; end
      JALR:   begin e.b_sel = 1'b1; e.pc_we = 1'b1; e.pc_sel = 2'd2; end
      default: e.b_sel = 1'b0;
    endcase
    step(1'($urandom), 1'($urandom), 7'($urandom), br, e, {tag, ":exec"});
    if (is_mem) begin
      e = quiet(3'd3); e.dmem_req = 1'b1; e.dmem_we = (opc == STORE);
      if (abort_mem) begin
        rst = 1'b1;
        step(1'($urandom), 1'b0, 7'($urandom), 1'($urandom), quiet(3'd3), {tag, ":rst_in_mem"});
        rst = 1'b0;
        e = quiet(3'd0); e.imem_req = 1'b1; e.ir_we = 1'b1;
        step(1'b1, 1'b1, 7'($urandom), 1'($urandom), e, {tag, ":after_rst"});
        return;
      end
      for (int i = 0; i < mw; i++)
        step(1'($urandom), 1'b0, 7'($urandom), 1'($urandom), e, {tag, ":mem_wait"});
      e.pc_we = (opc == STORE);
      step(1'($urandom), 1'b1, 7'($urandom), 1'($urandom), e, {tag, ":mem_done"});
    end
    if (opc != BRANCH && opc != STORE) begin
      e = quiet(3'd4); e.rf_we = 1'b1; e.pc_we = !is_jump;
      e.wb_sel = (opc == LOAD) ? 2'd1 : is_jump ? 2'd2 : (opc == LUI) ? 2'd3 : 2'd0;
      step(1'($urandom), 1'($urandom), 7'($urandom), 1'($urandom), e, {tag, ":wb"});
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    obs_t e;
    rst = 1'b1; op = 7'd0; func = 3'd0; br_taken = 1'b0;
    imem_ready = 1'b0; dmem_ready = 1'b0;
    @(posedge clk);
    #1;
    #2;
    check(quiet(3'd0), "reset_state");
    rst = 1'b0;

    run_instr(OPR,    1'b0, 0, 0, 1'b0, "op");
    run_instr(LOAD,   1'b0, 0, 3, 1'b0, "load_wait3");
    run_instr(BRANCH, 1'b1, 0, 0, 1'b0, "branch_taken");
    run_instr(BRANCH, 1'b0, 0, 0, 1'b0, "branch_not_taken");
    run_instr(JALR,   1'b0, 0, 0, 1'b0, "jalr");
    run_instr(JAL,    1'b0, 1, 0, 1'b0, "jal");
    run_instr(STORE,  1'b0, 4, 2, 1'b0, "store_fetch4");
    run_instr(LUI,    1'b0, 0, 0, 1'b0, "lui");
    run_instr(AUIPC,  1'b0, 0, 0, 1'b0, "auipc");

    for (int n = 0; n < 60; n++) begin
      logic [6:0] r_op;
      r_op = legal_ops[$urandom_range(0, 8)];
      run_instr(r_op, 1'($urandom), $urandom_range(0, 4), $urandom_range(0, 3), 1'b0,
                $sformatf("rand%0d_op%b", n, r_op));
    end

    run_instr(LOAD, 1'b0, 0, 0, 1'b1, "rst_mid_mem");
    do_reset();

    // Unsupported opcode: DECODE goes straight to an absorbing HALT.
    e = quiet(3'd0); e.imem_req = 1'b1; e.ir_we = 1'b1;
    step(1'b1, 1'b0, 7'd0, 1'b0, e, "illegal:fetch");
    step(1'b1, 1'b1, 7'b0001111, 1'b0, quiet(3'd1), "illegal:decode");
    e = quiet(3'd5); e.halted = 1'b1; e.illegal = 1'b1;
    for (int i = 0; i < 20; i++)
      step(1'($urandom), 1'($urandom), 7'($urandom), 1'($urandom), e, "illegal:halt");
    do_reset();
    e = quiet(3'd0); e.imem_req = 1'b1;
    step(1'b0, 1'b0, 7'd0, 1'b0, e, "illegal:after_rst");
    do_reset();

    // Fetch timeout of 5: five waiting FETCH cycles, then HALT with illegal set.
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'($urandom), 7'($urandom), 1'($urandom), e, "timeout:fetch_wait");
    e = quiet(3'd5); e.halted = 1'b1; e.illegal = 1'b1;
    step(1'b0, 1'($urandom), 7'($urandom), 1'($urandom), e, "timeout:halt");
    step(1'b1, 1'b1, 7'($urandom), 1'($urandom), e, "timeout:halt_hold");
    do_reset();
    run_instr(OPIMM, 1'b0, 4, 0, 1'b0, "opimm_after_timeout");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
